// File: rtl/display_sched_pkg.sv
// Shared types and helpers for the display source scheduler.
package display_sched_pkg;

  typedef enum logic {MODE_MANUAL, MODE_AUTO} sched_mode_t;

  // Wraps explicitly so non-power-of-two source counts never reach num_src.
  function automatic int unsigned next_sel(int unsigned sel, int unsigned num_src);
    return (sel == num_src - 1) ? 0 : sel + 1;
  endfunction

endpackage

// File: rtl/display_source_scheduler_if.sv
// Button pulses, per-source digit inputs and selected display outputs of the scheduler.
interface display_source_scheduler_if #(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned NUM_SEGMENTS = 4,
  parameter int unsigned SEL_W        = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
);

  logic                         next_btn;
  logic                         mode_btn;
  logic [NUM_SEGMENTS-1:0][3:0] src_encoded     [NUM_SRC];
  logic [NUM_SEGMENTS-1:0]      src_digit_point [NUM_SRC];
  logic [NUM_SEGMENTS-1:0][3:0] encoded;
  logic [NUM_SEGMENTS-1:0]      digit_point;
  logic [SEL_W-1:0]             sel;
  logic                         auto_mode;
  logic                         sel_changed;

  modport master (
    output next_btn, mode_btn, src_encoded, src_digit_point,
    input  encoded, digit_point, sel, auto_mode, sel_changed
  );

  modport slave (
    input  next_btn, mode_btn, src_encoded, src_digit_point,
    output encoded, digit_point, sel, auto_mode, sel_changed
  );

endinterface

// File: rtl/dwell_timer.sv
// Counts enabled cycles and flags the last cycle of each DWELL_CYCLES-long dwell.
module dwell_timer #(
  parameter int unsigned DWELL_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam int unsigned CntW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CntW-1:0] Last = CntW'(DWELL_CYCLES - 1);

  logic [CntW-1:0] count_q, count_d;

  assign expire = enable && (count_q == Last);

  // Expiry reloads to zero so every dwell is exactly DWELL_CYCLES long.
  always_comb begin
    count_d = count_q + 1'b1;
    if (clear || expire || !enable) count_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/display_source_scheduler.sv
// Picks one of NUM_SRC counter sources for the shared seven-segment display,
// stepped by a button (MANUAL) or rotated after a fixed dwell (AUTO).
module display_source_scheduler
  import display_sched_pkg::*;
#(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned NUM_SEGMENTS = 4,
  parameter int unsigned CLK_PER      = 10,
  parameter int unsigned DWELL_MS     = 2000,
  parameter int unsigned DWELL_CYCLES = DWELL_MS * 1_000_000 / CLK_PER,
  parameter int unsigned SEL_W        = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
  input logic                        clk,
  input logic                        reset,
  display_source_scheduler_if.slave  bus
);

  sched_mode_t                  mode_q, mode_d;
  logic [SEL_W-1:0]             sel_q, sel_d;
  logic                         advance;
  logic                         expire;
  logic                         adv_q;
  logic                         sel_changed_q;
  logic [NUM_SEGMENTS-1:0][3:0] encoded_q;
  logic [NUM_SEGMENTS-1:0]      dp_q;

  dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dwell_timer (
    .clk   (clk),
    .reset (reset),
    .enable(mode_q == MODE_AUTO),
    .clear (advance || bus.mode_btn || (mode_q == MODE_MANUAL)),
    .expire(expire)
  );

  // A button press and a dwell expiry in the same cycle merge into one advance.
  always_comb begin
    mode_d  = mode_q;
    sel_d   = sel_q;
    advance = bus.next_btn || expire;
    if (bus.mode_btn) mode_d = (mode_q == MODE_AUTO) ? MODE_MANUAL : MODE_AUTO;
    if (advance) sel_d = SEL_W'(next_sel(32'(sel_q), NUM_SRC));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q        <= MODE_MANUAL;
      sel_q         <= '0;
      adv_q         <= 1'b0;
      sel_changed_q <= 1'b0;
      encoded_q     <= '0;
      dp_q          <= '0;
    end else begin
      mode_q        <= mode_d;
      sel_q         <= sel_d;
      adv_q         <= advance;
      // Delayed a second cycle so it lines up with the mux output switching.
      sel_changed_q <= adv_q;
      encoded_q     <= bus.src_encoded[sel_q];
      dp_q          <= bus.src_digit_point[sel_q];
    end
  end

  assign bus.encoded     = encoded_q;
  assign bus.digit_point = dp_q;
  assign bus.sel         = sel_q;
  assign bus.auto_mode   = (mode_q == MODE_AUTO);
  assign bus.sel_changed = sel_changed_q;

endmodule

// File: tb/tb_display_source_scheduler.sv
// Randomized scoreboard bench for display_source_scheduler against a cycle-count model.
module tb_display_source_scheduler;

  localparam int NSRC  = 3;
  localparam int NSEG  = 4;
  localparam int DWELL = 8;

  logic clk;
  logic reset;

  display_source_scheduler_if #(.NUM_SRC(NSRC), .NUM_SEGMENTS(NSEG)) bus ();

  display_source_scheduler #(
    .NUM_SRC     (NSRC),
    .NUM_SEGMENTS(NSEG),
    .DWELL_CYCLES(DWELL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int edge_no;
    int sel;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int total = 0;
  int bad   = 0;
  // Model: selection, mode, edge index and edge at which the current dwell began.
  int m_sel = 0;
  int m_auto = 0;
  int m_edge = 0;
  int m_start = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, exp, m_edge);
    end
  endtask

  task automatic step(input bit nb, input bit mb);
    logic [15:0] exp_enc;
    logic [3:0]  exp_dp;
    bit          adv;
    bus.next_btn = nb;
    bus.mode_btn = mb;
    exp_enc = bus.src_encoded[m_sel];
    exp_dp  = bus.src_digit_point[m_sel];
    @(posedge clk);
    m_edge++;
    adv = nb || (m_auto != 0 && (m_edge - m_start) == DWELL);
    if (adv) begin
      m_sel = (m_sel + 1) % NSRC;
      sb.push_back('{m_edge + 1, m_sel});
    end
    if (mb) m_auto = (m_auto != 0) ? 0 : 1;
    if (adv || mb) m_start = m_edge;
    #1;
    chk("sel", 32'(bus.sel), m_sel);
    chk("auto_mode", 32'(bus.auto_mode), m_auto);
    chk("encoded", 32'(bus.encoded), 32'(exp_enc));
    chk("digit_point", 32'(bus.digit_point), 32'(exp_dp));
    #1;
    bus.next_btn = 1'b0;
    bus.mode_btn = 1'b0;
  endtask

  // Monitor: every sel_changed pulse must match the oldest predicted advance.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].edge_no < m_edge) begin
        e = sb.pop_front();
        total++;
        bad++;
        $display("FAIL sel_changed_missing: got none want pulse at edge %0d", e.edge_no);
      end
      if (!reset && bus.sel_changed === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sel_changed_spurious: got 1 want 0 (edge %0d)", m_edge);
        end else begin
          e = sb.pop_front();
          chk("sel_changed_edge", m_edge, e.edge_no);
          chk("changed_encoded", 32'(bus.encoded), 32'(bus.src_encoded[e.sel]));
          chk("changed_dp", 32'(bus.digit_point), 32'(bus.src_digit_point[e.sel]));
        end
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] nib;
    reset        = 1'b1;
    bus.next_btn = 1'b0;
    bus.mode_btn = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      nib = 4'(k + 1);
      bus.src_encoded[k]     = {4{nib}};
      bus.src_digit_point[k] = 4'($urandom);
    end
    #12;
    chk("rst_sel", 32'(bus.sel), 0);
    chk("rst_encoded", 32'(bus.encoded), 0);
    chk("rst_auto", 32'(bus.auto_mode), 0);
    chk("rst_changed", 32'(bus.sel_changed), 0);
    #10 reset = 1'b0;
    #1;
    chk("post_rst_encoded", 32'(bus.encoded), 0);

    // Idle, then three manual advances five cycles apart.
    repeat (4) step(0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0);
      repeat (4) step(0, 0);
    end

    // AUTO rotation.
    step(0, 1);
    repeat (26) step(0, 0);

    // next_btn landing exactly in the expiry cycle.
    for (int i = 0; i < 2 * DWELL && !(m_edge + 1 - m_start == DWELL); i++) step(0, 0);
    step(1, 0);
    repeat (20) step(0, 0);

    // AUTO->MANUAL on the expiry cycle still advances once.
    for (int i = 0; i < 2 * DWELL && !(m_edge + 1 - m_start == DWELL); i++) step(0, 0);
    step(0, 1);
    repeat (6) step(0, 0);

    // mode and next together from MANUAL with sel=2.
    for (int i = 0; i < 5 && m_sel != 2; i++) begin
      step(1, 0);
      step(0, 0);
    end
    step(1, 1);
    repeat (12) step(0, 0);

    // Reset five cycles into a dwell on source 1, with a pulse held during reset.
    for (int i = 0; i < 40 && !(m_auto != 0 && m_sel == 1 && m_edge - m_start == 5); i++)
      step(0, 0);
    #3;
    reset = 1'b1;
    bus.next_btn = 1'b1;
    sb.delete();
    #1;
    chk("mid_rst_sel", 32'(bus.sel), 0);
    chk("mid_rst_encoded", 32'(bus.encoded), 0);
    chk("mid_rst_auto", 32'(bus.auto_mode), 0);
    chk("mid_rst_dp", 32'(bus.digit_point), 0);
    repeat (2) @(posedge clk);
    #2;
    bus.next_btn = 1'b0;
    #2;
    reset   = 1'b0;
    m_sel   = 0;
    m_auto  = 0;
    m_start = m_edge;
    #1;
    chk("rel_encoded", 32'(bus.encoded), 0);
    repeat (20) step(0, 0);

    // Random pulses and live source changes.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        bus.src_encoded[$urandom_range(0, NSRC - 1)]     = 16'($urandom);
        bus.src_digit_point[$urandom_range(0, NSRC - 1)] = 4'($urandom);
      end
      step($urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0);
    end

    repeat (3) step(0, 0);
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_source_scheduler.md
Name: display_source_scheduler

Overview:
- Shares one seven_segment display between NUM_SRC counter sources, for example hex and decimal counters per button.
- Selects which source's encoded digits and digit points drive the display.
- Two selection modes: MANUAL, where a debounced button steps through sources, and AUTO, where sources rotate after a fixed dwell time.
- Sits between the counter instances and seven_segment; it is fed by button_debouncer pulses.

Parameters:
- NUM_SRC, 4, number of selectable sources; must be at least 2.
- NUM_SEGMENTS, 4, digits per source and per display.
- CLK_PER, 10, clock period in ns.
- DWELL_MS, 2000, AUTO-mode dwell per source in ms.
- DWELL_CYCLES, DWELL_MS*1_000_000/CLK_PER, dwell length in clocks; benches override it directly.
- SEL_W, max(1,$clog2(NUM_SRC)), width of the select index (derived).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- next_btn  in  1  one-cycle pulse from button_debouncer; advances the selection.
- mode_btn  in  1  one-cycle pulse; toggles between MANUAL and AUTO.
- src_encoded  in  [NUM_SEGMENTS-1:0][3:0] x NUM_SRC (unpacked)  per-source digit values.
- src_digit_point  in  [NUM_SEGMENTS-1:0] x NUM_SRC (unpacked)  per-source decimal points.
- encoded  out  [NUM_SEGMENTS-1:0][3:0]  selected digits, to seven_segment.
- digit_point  out  [NUM_SEGMENTS-1:0]  selected decimal points, to seven_segment.
- sel  out  SEL_W  current source index.
- auto_mode  out  1  1 while in AUTO.
- sel_changed  out  1  one-cycle pulse in the cycle after sel updates.

Behaviour:
- Reset (asynchronous, active-high): state=MANUAL, sel=0, auto_mode=0, dwell count=0, encoded=0, digit_point=0, sel_changed=0. All outputs are registered.
- States:
  - MANUAL: only next_btn changes sel.
  - AUTO: next_btn and dwell expiry both change sel.
- Advance rule: sel <= (sel==NUM_SRC-1) ? 0 : sel+1. Wrap-around is mandatory even when NUM_SRC is not a power of 2; sel never takes a value of NUM_SRC or above.
- Dwell counter:
  - Counts only in AUTO.
  - Clears on entry to AUTO, on any advance, and in MANUAL.
  - Expiry occurs in the cycle where count==DWELL_CYCLES-1. That cycle causes an advance and reloads the count to 0.
  - Result: each source is shown for exactly DWELL_CYCLES clocks.
- mode_btn: MANUAL->AUTO or AUTO->MANUAL, effective next cycle; auto_mode follows the state register.
- Simultaneous events in the same cycle:
  - mode_btn and next_btn: toggle mode and advance once; the dwell counter clears.
  - next_btn and dwell expiry: advance exactly once; the dwell counter clears.
  - mode_btn (AUTO->MANUAL) and dwell expiry: the advance still occurs once; the new state is MANUAL.
- Datapath:
  - encoded <= src_encoded[sel] and digit_point <= src_digit_point[sel], evaluated every cycle.
  - Latency from a source change to the output is 1 clock.
  - After a sel update the output reflects the new source 1 clock later. sel_changed asserts in that same cycle.
- Source values may change at any time; the output follows them live and does not latch them.
- Reset mid-dwell or mid-pulse: everything returns to reset values immediately. Pulses arriving while reset is high are ignored.
- No handshake: the button inputs are single-cycle pulses. Inputs held high for several cycles count as one event per cycle; that is a debouncer violation and is not guarded against.

Decomposition:
- Package display_sched_pkg holds:
  - typedef enum logic {MODE_MANUAL, MODE_AUTO} sched_mode_t;
  - function next_sel(sel, num_src), which implements the wrap rule.
- One sub-module, dwell_timer. Ports: clk, reset, enable, clear, expire. Parameter: DWELL_CYCLES. Counter width is $clog2(DWELL_CYCLES).
- The scheduler FSM, the select register and the output mux stay in display_source_scheduler.

Test Plan (NUM_SRC=3, NUM_SEGMENTS=4, DWELL_CYCLES=8, src k encoded = {4{k+1}}):
- After reset deassert with no buttons: sel=0, auto_mode=0, encoded=0x0000 until the first clock, then 0x1111 held indefinitely.
- Three next_btn pulses 5 cycles apart: sel goes 1,2,0; encoded goes 0x2222, 0x3333, 0x1111, each one clock after its sel update; one sel_changed pulse per advance.
- One mode_btn pulse, then idle: sel advances every 8 clocks (0,1,2,0); encoded follows 1 clock later; auto_mode=1.
- In AUTO, next_btn in the expiry cycle: exactly one advance; the next advance comes 8 clocks later, not 16 and not 1.
- mode_btn and next_btn in the same cycle from MANUAL with sel=2: sel=0, auto_mode=1, next auto advance 8 clocks later.
- Reset asserted 5 clocks into a dwell with sel=1: outputs clear asynchronously (sel=0, encoded=0, auto_mode=0); after release the block stays in MANUAL with no spurious advance.
